// File: rtl/demuxtipo1_fifo.sv
// 1-to-2 buffered demultiplexer: steers one valid/ready byte stream into two per-channel
// FIFOs, each with its own output handshake and delivered-byte counter.
module demuxtipo1_fifo #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] entr,
  input  logic         entr_valid,
  output logic         entr_ready,
  input  logic         sinalt1,
  output logic [W-1:0] saida0,
  output logic         valid0,
  input  logic         ready0,
  output logic [W-1:0] saida1,
  output logic         valid1,
  input  logic         ready1,
  output logic [7:0]   cnt0,
  output logic [7:0]   cnt1
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned OccW = PtrW + 1;
  localparam logic [OccW-1:0] OccFull = OccW'(DEPTH);

  logic [1:0]   full;
  logic [1:0]   empty;
  logic [1:0]   rdy;
  logic [W-1:0] head [2];
  logic [7:0]   cnt  [2];

  assign rdy = {ready1, ready0};

  // Only registered occupancy and the select feed entr_ready; consumer readies never do.
  assign entr_ready = ~full[sinalt1];

  for (genvar k = 0; k < 2; k++) begin : g_ch
    logic [W-1:0]    mem_q [DEPTH];
    logic [PtrW-1:0] wptr_q;
    logic [PtrW-1:0] rptr_q;
    logic [PtrW-1:0] last_idx;
    logic [OccW-1:0] occ_q;
    logic [7:0]      cnt_q;
    logic            push;
    logic            pop;

    assign full[k]  = (occ_q == OccFull);
    assign empty[k] = (occ_q == '0);
    assign push     = entr_valid & ~full[k] & (sinalt1 == 1'(k));
    assign pop      = ~empty[k] & rdy[k];

    // When empty, the slot behind the read pointer still holds the last popped byte.
    assign last_idx = rptr_q - PtrW'(1);
    assign head[k]  = empty[k] ? mem_q[last_idx] : mem_q[rptr_q];
    assign cnt[k]   = cnt_q;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        mem_q  <= '{default: '0};
        wptr_q <= '0;
        rptr_q <= '0;
        occ_q  <= '0;
        cnt_q  <= '0;
      end else begin
        if (push) begin
          mem_q[wptr_q] <= entr;
          wptr_q        <= wptr_q + PtrW'(1);
        end
        if (pop) begin
          rptr_q <= rptr_q + PtrW'(1);
          cnt_q  <= cnt_q + 8'd1;
        end
        if (push && !pop) begin
          occ_q <= occ_q + OccW'(1);
        end else if (!push && pop) begin
          occ_q <= occ_q - OccW'(1);
        end
      end
    end
  end

  assign saida0 = head[0];
  assign saida1 = head[1];
  assign valid0 = ~empty[0];
  assign valid1 = ~empty[1];
  assign cnt0   = cnt[0];
  assign cnt1   = cnt[1];

endmodule
